// File: rtl/scr1_vadd_pipe_if.sv
// Handshake and payload bundle for the SCR1 vector add/subtract unit.
// The slave side is the unit; the master side is the operand source / result sink.
interface scr1_vadd_pipe_if #(
   parameter int unsigned LANES = 8
) ();
   localparam int unsigned DW = LANES * 32;
   localparam int unsigned CW = LANES * 4;

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_op1;
   logic [DW-1:0] in_op2;
   logic          in_sub;
   logic [1:0]    in_sew;
   logic          in_sat;
   logic          in_signed;
   logic [LANES-1:0] in_mask;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_res;
   logic [CW-1:0] out_cy;
   logic          vxsat;
   logic          vxsat_clr;

   modport master (
      output in_valid, input in_ready,
      output in_op1, in_op2, in_sub, in_sew, in_sat, in_signed, in_mask,
      input  out_valid, output out_ready,
      input  out_res, out_cy, vxsat,
      output vxsat_clr
   );

   modport slave (
      input  in_valid, output in_ready,
      input  in_op1, in_op2, in_sub, in_sew, in_sat, in_signed, in_mask,
      output out_valid, input out_ready,
      output out_res, out_cy, vxsat,
      input  vxsat_clr
   );
endinterface

// File: rtl/scr1_vadd_pipe.sv
// Two-stage pipelined SIMD add/subtract: 8/16/32-bit elements per 32-bit lane,
// wrapping or saturating, per-lane masking, per-element carry flags, sticky vxsat.
module scr1_vadd_pipe #(
   parameter int unsigned LANES = 8
) (
   input  logic             clk,
   input  logic             rst,
   scr1_vadd_pipe_if.slave  bus
);
   localparam int unsigned DW = LANES * 32;
   localparam int unsigned CW = LANES * 4;
   localparam logic [1:0]  SEW8  = 2'b00;
   localparam logic [1:0]  SEW16 = 2'b01;

   // Byte b starts an element (takes the fresh carry-in).
   function automatic logic f_elem_lsb(input logic [1:0] b, input logic [1:0] sew);
      return (sew == SEW8) || (b == 2'd0) || ((sew == SEW16) && (b == 2'd2));
   endfunction

   // Byte b is the most-significant byte of its element.
   function automatic logic f_elem_msb(input logic [1:0] b, input logic [1:0] sew);
      return (sew == SEW8) || (b == 2'd3) || ((sew == SEW16) && (b == 2'd1));
   endfunction

   function automatic logic [1:0] f_elem_top(input logic [1:0] b, input logic [1:0] sew);
      if (sew == SEW8)  return b;
      if (sew == SEW16) return {b[1], 1'b1};
      return 2'd3;
   endfunction

   // Saturation byte pattern: signed max/min carries the sign in the top byte only.
   function automatic logic [7:0] f_fill(input logic is_top, input logic neg, input logic sgn);
      if (sgn && is_top) return neg ? 8'h80 : 8'h7F;
      return neg ? 8'h00 : 8'hFF;
   endfunction

   logic             r_s1_valid;
   logic [DW-1:0]    r_s1_op1;
   logic [DW-1:0]    r_s1_op2;
   logic             r_s1_sub;
   logic [1:0]       r_s1_sew;
   logic             r_s1_sat;
   logic             r_s1_signed;
   logic [LANES-1:0] r_s1_mask;

   logic             r_s2_valid;
   logic [DW-1:0]    r_s2_res;
   logic [CW-1:0]    r_s2_cy;
   logic             r_s2_sat;
   logic             r_vxsat;

   logic             w_s2_adv;
   logic             w_in_ready;
   logic             w_s1_load;
   logic             w_xfer;
   logic [DW-1:0]    w_res;
   logic [CW-1:0]    w_cy;
   logic             w_sat;

   assign w_s2_adv   = !r_s2_valid || bus.out_ready;
   assign w_in_ready = !r_s1_valid || w_s2_adv;
   assign w_s1_load  = bus.in_valid && w_in_ready;
   assign w_xfer     = r_s2_valid && bus.out_ready;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_s2_valid;
   assign bus.out_res   = r_s2_res;
   assign bus.out_cy    = r_s2_cy;
   assign bus.vxsat     = r_vxsat;

   // S1: operand/control capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
      end else if (w_s1_load) begin
         r_s1_valid  <= 1'b1;
         r_s1_op1    <= bus.in_op1;
         r_s1_op2    <= bus.in_op2;
         r_s1_sub    <= bus.in_sub;
         r_s1_sew    <= bus.in_sew;
         r_s1_sat    <= bus.in_sat;
         r_s1_signed <= bus.in_signed;
         r_s1_mask   <= bus.in_mask;
      end else if (w_s2_adv) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Byte-sliced adders with the carry chain cut at element boundaries.
   always_comb begin : p_arith
      logic [8:0] v_sum  [4];
      logic [7:0] v_a    [4];
      logic [7:0] v_bx   [4];
      logic       v_esat [4];
      logic       v_eneg [4];
      logic       v_cin;
      logic       v_flag;
      logic       v_ovf;
      logic [1:0] v_t;

      w_res  = '0;
      w_cy   = '0;
      w_sat  = 1'b0;
      v_sum  = '{default: '0};
      v_a    = '{default: '0};
      v_bx   = '{default: '0};
      v_esat = '{default: 1'b0};
      v_eneg = '{default: 1'b0};
      v_cin  = 1'b0;
      v_flag = 1'b0;
      v_ovf  = 1'b0;
      v_t    = 2'd0;

      for (int l = 0; l < int'(LANES); l++) begin
         v_cin = 1'b0;
         for (int b = 0; b < 4; b++) begin
            v_a[b]  = r_s1_op1[l*32 + b*8 +: 8];
            v_bx[b] = r_s1_op2[l*32 + b*8 +: 8] ^ {8{r_s1_sub}};
            if (f_elem_lsb(2'(b), r_s1_sew)) v_cin = r_s1_sub;
            v_sum[b] = 9'(v_a[b]) + 9'(v_bx[b]) + 9'(v_cin);
            v_cin    = v_sum[b][8];
         end

         // Per-element flags, evaluated at each element's top byte.
         for (int b = 0; b < 4; b++) begin
            v_esat[b] = 1'b0;
            v_eneg[b] = 1'b0;
            if (f_elem_msb(2'(b), r_s1_sew)) begin
               v_flag = v_sum[b][8] ^ r_s1_sub;
               v_ovf  = (v_a[b][7] == v_bx[b][7]) && (v_sum[b][7] != v_a[b][7]);
               if (r_s1_signed) begin
                  v_esat[b] = r_s1_sat && v_ovf;
                  v_eneg[b] = v_a[b][7];
               end else begin
                  v_esat[b] = r_s1_sat && v_flag;
                  v_eneg[b] = r_s1_sub;
               end
               if (r_s1_mask[l]) begin
                  w_cy[l*4 + b] = v_flag;
                  w_sat         = w_sat | v_esat[b];
               end
            end
         end

         for (int b = 0; b < 4; b++) begin
            v_t = f_elem_top(2'(b), r_s1_sew);
            if (!r_s1_mask[l]) begin
               w_res[l*32 + b*8 +: 8] = v_a[b];
            end else if (v_esat[v_t]) begin
               w_res[l*32 + b*8 +: 8] = f_fill(2'(b) == v_t, v_eneg[v_t], r_s1_signed);
            end else begin
               w_res[l*32 + b*8 +: 8] = v_sum[b][7:0];
            end
         end
      end
   end

   // S2: result register, held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_res   <= '0;
         r_s2_cy    <= '0;
         r_s2_sat   <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_res <= w_res;
            r_s2_cy  <= w_cy;
            r_s2_sat <= w_sat;
         end
      end
   end

   // Sticky saturation: a saturating transfer beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vxsat <= 1'b0;
      end else if (w_xfer && r_s2_sat) begin
         r_vxsat <= 1'b1;
      end else if (bus.vxsat_clr) begin
         r_vxsat <= 1'b0;
      end
   end
endmodule
